sprite_row_writer: RTL and testbench



---
 rtl/sprite_row_writer_pkg.sv | 18 +
 rtl/sprite_row_writer_if.sv | 32 +++
 rtl/sprite_row_packer.sv | 50 +++++
 rtl/sprite_row_writer.sv | 131 +++++++++++++
 tb/tb_sprite_row_writer.sv | 331 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_row_writer_pkg.sv
// Shared sprite geometry and pixel/row types used by the writer and the renderer.
package sprite_row_writer_pkg;

  localparam int unsigned SPRITE_W = 32;
  localparam int unsigned SPRITE_H = 32;
  localparam int unsigned BPP      = 3;
  localparam int unsigned ROW_BITS = SPRITE_W * BPP;
  localparam int unsigned ADDR_W   = $clog2(SPRITE_H);
  localparam int unsigned PX_CNT_W = $clog2(SPRITE_W);

  typedef logic [BPP-1:0]      pixel_t;
  typedef logic [ROW_BITS-1:0] row_t;
  typedef logic [ADDR_W-1:0]   row_addr_t;

  // Transparent colour; stored in the row word like any other colour.
  localparam pixel_t TRANSPARENT_PX = '0;

endpackage

// File: rtl/sprite_row_writer_if.sv
// Pixel stream handshake plus row RAM write port of the sprite row writer.
interface sprite_row_writer_if;
  import sprite_row_writer_pkg::*;

  pixel_t    px_data;
  logic      px_valid;
  logic      px_ready;
  logic      wr_en;
  row_addr_t wr_addr;
  row_t      wr_data;

  // Writer side: consumes pixels, drives the RAM write port.
  modport master (
    input  px_data,
    input  px_valid,
    output px_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  // Pixel source / row RAM side.
  modport slave (
    output px_data,
    output px_valid,
    input  px_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/sprite_row_packer.sv
// Shifts accepted pixels into a row word, column 0 ending up in the top bits.
module sprite_row_packer
  import sprite_row_writer_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clr,
  input  logic   accept,
  input  pixel_t px_data,
  output logic   row_complete_c,
  output row_t   row_c
);

  // Only the first SPRITE_W-1 pixels are held; the last pixel of a row is
  // merged in combinationally so the completed row leaves without a bubble.
  localparam int unsigned HIST_BITS = ROW_BITS - BPP;

  logic [HIST_BITS-1:0] pack_q, pack_d;
  logic [PX_CNT_W-1:0]  px_cnt_q, px_cnt_d;
  logic                 last_px_c;

  assign last_px_c      = (px_cnt_q == PX_CNT_W'(SPRITE_W - 1));
  assign row_c          = {pack_q, px_data};
  assign row_complete_c = accept && last_px_c;

  // Next pack/count: clear wins over accept, count wraps at row end.
  always_comb begin
    pack_d   = pack_q;
    px_cnt_d = px_cnt_q;
    if (clr) begin
      pack_d   = {(SPRITE_W - 1){TRANSPARENT_PX}};
      px_cnt_d = '0;
    end else if (accept) begin
      pack_d   = row_c[HIST_BITS-1:0];
      px_cnt_d = last_px_c ? '0 : px_cnt_q + PX_CNT_W'(1);
    end
  end

  // Pack register and column counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pack_q   <= '0;
      px_cnt_q <= '0;
    end else begin
      pack_q   <= pack_d;
      px_cnt_q <= px_cnt_d;
    end
  end

endmodule

// File: rtl/sprite_row_writer.sv
// Loads a serial sprite pixel stream into the row RAM one packed row at a time.
module sprite_row_writer
  import sprite_row_writer_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       abort,
  sprite_row_writer_if.master        bus,
  output logic                       busy,
  output logic                       done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_FLUSH,
    S_DONE
  } state_e;

  state_e    state_q, state_d;
  row_addr_t row_cnt_q, row_cnt_d;
  logic      px_ready_q, px_ready_d;
  logic      busy_q, busy_d;
  logic      done_q, done_d;
  logic      wr_en_q, wr_en_d;
  row_addr_t wr_addr_q, wr_addr_d;
  row_t      wr_data_q, wr_data_d;

  logic      accept_c;
  logic      clr_c;
  logic      row_complete_c;
  row_t      row_c;

  assign accept_c = bus.px_valid && px_ready_q;

  sprite_row_packer u_packer (
    .clk            (clk),
    .rst            (rst),
    .clr            (clr_c),
    .accept         (accept_c),
    .px_data        (bus.px_data),
    .row_complete_c (row_complete_c),
    .row_c          (row_c)
  );

  // Next state, row counter and output register; abort suppresses a same-cycle row write.
  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    clr_c     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LOAD;
          row_cnt_d = '0;
          clr_c     = 1'b1;
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
          clr_c     = 1'b1;
        end else if (row_complete_c) begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_cnt_q;
          wr_data_d = row_c;
          row_cnt_d = row_cnt_q + ADDR_W'(1);
          if (row_cnt_q == ADDR_W'(SPRITE_H - 1)) begin
            state_d = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (abort) begin
          state_d   = S_IDLE;
          row_cnt_d = '0;
          clr_c     = 1'b1;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    px_ready_d = (state_d == S_LOAD);
    busy_d     = (state_d == S_LOAD) || (state_d == S_FLUSH);
    done_d     = (state_d == S_DONE);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      row_cnt_q  <= '0;
      px_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      row_cnt_q  <= row_cnt_d;
      px_ready_q <= px_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign bus.px_ready = px_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_sprite_row_writer.sv
// Self-checking bench for sprite_row_writer: row scoreboard, RAM model, corner sequences.
module tb_sprite_row_writer;
  import sprite_row_writer_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy;
  logic done;

  sprite_row_writer_if u_if ();

  sprite_row_writer dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .abort (abort),
    .bus   (u_if),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [ADDR_W-1:0]   addr;
    logic [ROW_BITS-1:0] data;
  } wr_exp_t;
  wr_exp_t exp_q[$];

  typedef struct {
    string               name;
    int                  kind;
    logic [ROW_BITS-1:0] exp_word;
  } vec_t;
  vec_t tbl[6];

  logic [ROW_BITS-1:0] ram      [SPRITE_H];
  logic [ROW_BITS-1:0] ram_full [SPRITE_H];

  int                  m_col = 0;
  int                  m_row = 0;
  logic [ROW_BITS-1:0] m_word = '0;

  int   wr_cnt = 0;
  int   done_cnt = 0;
  logic prev_wr = 1'b0;
  logic rst_edge;
  logic [ADDR_W-1:0]   last_addr = '0;
  logic [ROW_BITS-1:0] last_data = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] pat(input int kind, input int c);
    case (kind)
      0:       return 3'(c % 8);
      1:       return 3'b111;
      2:       return 3'b000;
      3:       return 3'(7 - (c % 8));
      4:       return (c % 2 == 0) ? 3'b101 : 3'b010;
      default: return 3'((c * 3) % 8);
    endcase
  endfunction

  function automatic logic [2:0] pix(input int i);
    int r;
    int c;
    r = i / 32;
    c = i % 32;
    if (r < 6) return pat(tbl[r].kind, c);
    return 3'((r * 5 + c * 3 + c / 4) % 8);
  endfunction

  // Write-port monitor: scoreboard pop, RAM model, hold and spacing rules.
  always @(posedge clk) begin
    rst_edge = rst;
    #1;
    if (rst_edge) begin
      last_addr = '0;
      last_data = '0;
      prev_wr   = 1'b0;
    end else begin
      if (u_if.wr_en) begin
        chk("wr_en_back_to_back", 128'(prev_wr), 128'(0));
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_wr_en: got wr_en=1 addr=%0d expected no write at %0t", u_if.wr_addr, $time);
        end else begin
          wr_exp_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 128'(u_if.wr_addr), 128'(e.addr));
          chk("wr_data", 128'(u_if.wr_data), 128'(e.data));
        end
        ram[u_if.wr_addr] = u_if.wr_data;
        last_addr = u_if.wr_addr;
        last_data = u_if.wr_data;
        wr_cnt++;
      end else begin
        chk("wr_addr_hold", 128'(u_if.wr_addr), 128'(last_addr));
        chk("wr_data_hold", 128'(u_if.wr_data), 128'(last_data));
      end
      prev_wr = u_if.wr_en;
      if (done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    u_if.px_valid = 1'b0;
    repeat (n) begin
      u_if.px_data = 3'($urandom);
      tick();
    end
  endtask

  task automatic do_start(input bit with_abort);
    start = 1'b1;
    abort = with_abort;
    tick();
    start = 1'b0;
    abort = 1'b0;
    m_col = 0;
    m_row = 0;
    m_word = '0;
    chk("start_busy", 128'(busy), 128'(1));
    chk("start_px_ready", 128'(u_if.px_ready), 128'(1));
    chk("start_done", 128'(done), 128'(0));
  endtask

  // Drives one pixel that the bench expects to be accepted on the next edge.
  task automatic send_px(input logic [2:0] d, input bit do_abort, input bit do_start_pulse);
    bit                row_end;
    logic [ADDR_W-1:0] row_addr;
    row_end  = 1'b0;
    row_addr = '0;
    chk("px_ready_load", 128'(u_if.px_ready), 128'(1));
    chk("busy_load", 128'(busy), 128'(1));
    u_if.px_valid = 1'b1;
    u_if.px_data  = d;
    abort = do_abort;
    start = do_start_pulse;
    if (do_abort) begin
      m_col = 0;
      m_row = 0;
      m_word = '0;
    end else begin
      m_word[ROW_BITS-1-BPP*m_col -: BPP] = d;
      if (m_col == 31) begin
        exp_q.push_back('{addr: ADDR_W'(m_row), data: m_word});
        row_end  = 1'b1;
        row_addr = ADDR_W'(m_row);
        m_col = 0;
        m_row = (m_row + 1) % 32;
        m_word = '0;
      end else begin
        m_col++;
      end
    end
    tick();
    abort = 1'b0;
    start = 1'b0;
    if (row_end) begin
      chk("wr_en_latency", 128'(u_if.wr_en), 128'(1));
      chk("wr_addr_latency", 128'(u_if.wr_addr), 128'(row_addr));
    end
  endtask

  task automatic load_image(input int density, input int start_at);
    for (int i = 0; i < SPRITE_W * SPRITE_H; i++) begin
      if (density < 100) begin
        while ($urandom_range(0, 99) >= density) begin
          u_if.px_valid = 1'b0;
          u_if.px_data  = 3'($urandom);
          tick();
          chk("busy_throttle", 128'(busy), 128'(1));
        end
      end
      send_px(pix(i), 1'b0, i == start_at);
    end
    u_if.px_valid = 1'b0;
  endtask

  // Called right after the final accept: one FLUSH cycle, then a single done pulse.
  task automatic check_finish();
    int d0;
    d0 = done_cnt;
    chk("flush_wr_en", 128'(u_if.wr_en), 128'(1));
    chk("flush_busy", 128'(busy), 128'(1));
    chk("flush_px_ready", 128'(u_if.px_ready), 128'(0));
    chk("flush_done", 128'(done), 128'(0));
    tick();
    chk("done_pulse", 128'(done), 128'(1));
    chk("done_busy", 128'(busy), 128'(0));
    chk("done_wr_en", 128'(u_if.wr_en), 128'(0));
    tick();
    chk("done_fall", 128'(done), 128'(0));
    chk("done_once", 128'(done_cnt), 128'(d0 + 1));
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
  endtask

  initial begin
    int w0;
    int d0;

    tbl[0] = '{"bit_order_mod8", 0, {4{24'h053977}}};
    tbl[1] = '{"all_seven",      1, {24{4'hF}}};
    tbl[2] = '{"transparent",    2, '0};
    tbl[3] = '{"descending",     3, {4{24'hFAC688}}};
    tbl[4] = '{"alt_5_2",        4, {24{4'hA}}};
    tbl[5] = '{"times_three",    5, {4{24'h0F19D5}}};

    u_if.px_valid = 1'b0;
    u_if.px_data  = '0;
    repeat (3) tick();
    chk("rst_px_ready", 128'(u_if.px_ready), 128'(0));
    chk("rst_wr_en", 128'(u_if.wr_en), 128'(0));
    chk("rst_wr_addr", 128'(u_if.wr_addr), 128'(0));
    chk("rst_wr_data", 128'(u_if.wr_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_done", 128'(done), 128'(0));
    rst = 1'b0;

    // Pixels and abort while idle are ignored.
    u_if.px_valid = 1'b1;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (40) tick();
    chk("idle_busy", 128'(busy), 128'(0));
    chk("idle_px_ready", 128'(u_if.px_ready), 128'(0));
    u_if.px_valid = 1'b0;

    // Full-rate load; first rows come from the vector table.
    w0 = wr_cnt;
    do_start(1'b0);
    load_image(100, -1);
    check_finish();
    chk("full_rate_writes", 128'(wr_cnt - w0), 128'(32));
    for (int v = 0; v < 6; v++) chk(tbl[v].name, 128'(ram[v]), 128'(tbl[v].exp_word));
    for (int r = 0; r < SPRITE_H; r++) begin
      for (int c = 0; c < SPRITE_W; c++) begin
        chk("render_px", 128'(ram[r][ROW_BITS-1-BPP*c -: BPP]), 128'(pix(r * 32 + c)));
      end
      ram_full[r] = ram[r];
    end

    // Throttled source at roughly 30% density.
    w0 = wr_cnt;
    do_start(1'b0);
    load_image(30, -1);
    check_finish();
    chk("throttle_writes", 128'(wr_cnt - w0), 128'(32));
    for (int r = 0; r < SPRITE_H; r++) chk("throttle_row", 128'(ram[r]), 128'(ram_full[r]));

    // Abort together with the last accept of row 5.
    d0 = done_cnt;
    w0 = wr_cnt;
    do_start(1'b0);
    for (int i = 0; i < 192; i++) send_px(pix(i), i == 191, 1'b0);
    u_if.px_valid = 1'b0;
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_px_ready", 128'(u_if.px_ready), 128'(0));
    chk("abort_wr_en", 128'(u_if.wr_en), 128'(0));
    idle(5);
    chk("abort_no_done", 128'(done_cnt), 128'(d0));
    chk("abort_writes", 128'(wr_cnt - w0), 128'(5));

    // Restart after abort, with a start pulse ignored mid-load.
    w0 = wr_cnt;
    do_start(1'b0);
    load_image(100, 100);
    check_finish();
    chk("restart_writes", 128'(wr_cnt - w0), 128'(32));

    // Reset in the middle of a load.
    do_start(1'b0);
    for (int i = 0; i < 500; i++) send_px(pix(i), 1'b0, 1'b0);
    rst = 1'b1;
    u_if.px_valid = 1'b1;
    u_if.px_data  = pix(500);
    tick();
    rst = 1'b0;
    m_col = 0;
    m_row = 0;
    m_word = '0;
    chk("midrst_px_ready", 128'(u_if.px_ready), 128'(0));
    chk("midrst_wr_en", 128'(u_if.wr_en), 128'(0));
    chk("midrst_wr_addr", 128'(u_if.wr_addr), 128'(0));
    chk("midrst_wr_data", 128'(u_if.wr_data), 128'(0));
    chk("midrst_busy", 128'(busy), 128'(0));
    chk("midrst_done", 128'(done), 128'(0));
    repeat (3) tick();
    u_if.px_valid = 1'b0;

    // start and abort together in idle: start is taken, first row lands at 0.
    w0 = wr_cnt;
    do_start(1'b1);
    for (int i = 0; i < 42; i++) send_px(3'((i * 5 + 1) % 8), 1'b0, 1'b0);
    send_px(3'b110, 1'b1, 1'b0);
    u_if.px_valid = 1'b0;
    chk("final_abort_busy", 128'(busy), 128'(0));
    idle(3);
    chk("final_writes", 128'(wr_cnt - w0), 128'(1));
    chk("final_queue_empty", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
